sig_verify: RTL and testbench

SIG_VERIFY -- requirements
Module: sig_verify

---
 rtl/sig_verify.sv | 178 +++++++++++++++++
 tb/tb_sig_verify.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sig_verify.sv
// sig_verify: RSA-style signature check.
// Computes s^e mod n by left-to-right square-and-multiply. Each modular
// multiply is an interleaved bit-serial loop with conditional-subtraction
// reduction, so no divider is needed. The result is then compared against
// the expected message m.
module sig_verify #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   s,
   input  logic [WIDTH-1:0]     e,
   input  logic [2*WIDTH-1:0]   n,
   input  logic [2*WIDTH-1:0]   m,
   output logic [2*WIDTH-1:0]   result,
   output logic                 busy,
   output logic                 finish,
   output logic                 valid,
   output logic                 err,
   output logic [15:0]          cycles
);

   localparam int KW = 2 * WIDTH;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int BW = $clog2(KW);
   localparam logic [BW-1:0] BCNT_MAX = BW'(KW - 1);
   localparam logic [IW-1:0] IDX_MAX  = IW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

   state_t          state;
   logic            pend;       // operands latched, range check due next cycle
   logic [IW-1:0]   idx;
   logic [BW-1:0]   bcnt;

   logic [KW-1:0]   s_l, n_l, m_l;
   logic [WIDTH-1:0] e_l;
   logic [KW-1:0]   x;
   logic [KW-1:0]   acc;

   logic            accept;
   logic            range_err;
   logic [KW-1:0]   mul_b;
   logic [KW-1:0]   mm_next;

   // Reduce a value known to be below 2*n into [0, n).
   function automatic logic [KW+1:0] cond_sub(input logic [KW+1:0] t,
                                             input logic [KW+1:0] nx);
      return (t >= nx) ? (t - nx) : t;
   endfunction

   // One interleaved multiply step: acc = ((2*acc mod n) + bit*a) mod n.
   function automatic logic [KW-1:0] mod_step(input logic [KW-1:0] acc_in,
                                              input logic [KW-1:0] a_in,
                                              input logic [KW-1:0] n_in,
                                              input logic          add);
      logic [KW+1:0] t;
      logic [KW+1:0] nx;
      nx = {2'b00, n_in};
      t  = {1'b0, acc_in, 1'b0};
      t  = cond_sub(t, nx);
      if (add) t = t + {2'b00, a_in};
      t  = cond_sub(t, nx);
      return t[KW-1:0];
   endfunction

   // Cycle counter increment that sticks at all-ones.
   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   assign accept    = (state == IDLE) && !pend && start;
   assign range_err = (n_l < KW'(2)) || (s_l >= n_l) || (m_l >= n_l);

   // Multiplier operand selection and the next accumulator value.
   always_comb begin
      mul_b   = (state == MUL) ? s_l : x;
      mm_next = mod_step(acc, x, n_l, mul_b[bcnt]);
   end

   // Control FSM with registered outputs; reset aborts any operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         pend   <= 1'b0;
         idx    <= '0;
         bcnt   <= '0;
         result <= '0;
         busy   <= 1'b0;
         finish <= 1'b0;
         valid  <= 1'b0;
         err    <= 1'b0;
         cycles <= '0;
      end else begin
         finish <= 1'b0;
         case (state)
            IDLE: begin
               if (pend) begin
                  pend <= 1'b0;
                  if (range_err) begin
                     err   <= 1'b1;
                     state <= DONE;
                  end else begin
                     bcnt  <= BCNT_MAX;
                     state <= SQR;
                  end
               end else if (start) begin
                  pend   <= 1'b1;
                  busy   <= 1'b1;
                  valid  <= 1'b0;
                  err    <= 1'b0;
                  cycles <= '0;
                  idx    <= IDX_MAX;
               end else begin
                  busy <= 1'b0;
               end
            end
            SQR: begin
               cycles <= sat_inc(cycles);
               if (bcnt == '0) begin
                  bcnt <= BCNT_MAX;
                  if (e_l[idx]) begin
                     state <= MUL;
                  end else if (idx == '0) begin
                     state <= DONE;
                  end else begin
                     idx <= idx - 1'b1;
                  end
               end else begin
                  bcnt <= bcnt - 1'b1;
               end
            end
            MUL: begin
               cycles <= sat_inc(cycles);
               if (bcnt == '0) begin
                  bcnt <= BCNT_MAX;
                  if (idx == '0) begin
                     state <= DONE;
                  end else begin
                     idx   <= idx - 1'b1;
                     state <= SQR;
                  end
               end else begin
                  bcnt <= bcnt - 1'b1;
               end
            end
            DONE: begin
               result <= err ? '0 : x;
               valid  <= (x == m_l) && !err;
               finish <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Datapath: operand capture on accept, bit-serial multiply while busy.
   always_ff @(posedge clk) begin
      if (accept) begin
         s_l <= s;
         e_l <= e;
         n_l <= n;
         m_l <= m;
         x   <= KW'(1);
         acc <= '0;
      end else if ((state == SQR) || (state == MUL)) begin
         if (bcnt == '0) begin
            x   <= mm_next;
            acc <= '0;
         end else begin
            acc <= mm_next;
         end
      end
   end

endmodule

// File: tb/tb_sig_verify.sv
// Directed bench for sig_verify (WIDTH=8) with hand-computed results.
module tb_sig_verify;

   localparam int W = 8;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [2*W-1:0]  s;
   logic [W-1:0]    e;
   logic [2*W-1:0]  n;
   logic [2*W-1:0]  m;
   logic [2*W-1:0]  result;
   logic            busy;
   logic            finish;
   logic            valid;
   logic            err;
   logic [15:0]     cycles;

   int vectors;
   int miscompares;

   sig_verify #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .s      (s),
      .e      (e),
      .n      (n),
      .m      (m),
      .result (result),
      .busy   (busy),
      .finish (finish),
      .valid  (valid),
      .err    (err),
      .cycles (cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Launch one operation and check latency and all outputs at finish.
   // inj > 0 re-asserts start (with scrambled operands) that many cycles in.
   task automatic run(input string tag, input logic [15:0] sv, input logic [7:0] ev,
                      input logic [15:0] nv, input logic [15:0] mv, input int exp_lat,
                      input logic [15:0] exp_res, input logic exp_valid,
                      input logic exp_err, input logic [15:0] exp_cyc, input int inj);
      int  lat;
      bit  done;
      s = sv; e = ev; n = nv; m = mv;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_busy_on"}, busy, 1'b1);
      lat  = 0;
      done = 0;
      while (!done && lat < 3000) begin
         if (inj > 0 && lat == inj) begin
            start = 1'b1;
            s = 16'd3; e = 8'hFF; n = 16'd7; m = 16'd0;
         end
         @(posedge clk); #1;
         start = 1'b0;
         lat++;
         if (finish) done = 1;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_result"}, result, exp_res);
      check({tag, "_valid"}, valid, exp_valid);
      check({tag, "_err"}, err, exp_err);
      check({tag, "_cycles"}, cycles, exp_cyc);
      check({tag, "_busy_fin"}, busy, 1'b1);
      @(posedge clk); #1;
      check({tag, "_finish_pulse"}, finish, 1'b0);
      check({tag, "_busy_off"}, busy, 1'b0);
      check({tag, "_valid_hold"}, valid, exp_valid);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n = 1'b0;
      start = 1'b0;
      s = '0; e = '0; n = '0; m = '0;
      #1;
      check("rst_result", result, 16'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_finish", finish, 1'b0);
      check("rst_valid", valid, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_cycles", cycles, 16'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 2^7 mod 143 = 128, 11 multiplies of 16 cycles each
      run("match",    16'd2,  8'd7, 16'd143, 16'd128, 178, 16'd128, 1'b1, 1'b0, 16'd176, 0);
      run("nomatch",  16'd2,  8'd7, 16'd143, 16'd127, 178, 16'd128, 1'b0, 1'b0, 16'd176, 0);
      // 10^3 = 1000 = 6*143 + 142
      run("e3",       16'd10, 8'd3, 16'd143, 16'd142, 162, 16'd142, 1'b1, 1'b0, 16'd160, 0);
      run("e0",       16'd10, 8'd0, 16'd143, 16'd1,   130, 16'd1,   1'b1, 1'b0, 16'd128, 0);
      // 3^255 mod 7 = 6 (3^6=1, 255 mod 6 = 3, 27 mod 7 = 6); 16*(8+8)=256
      run("eff",      16'd3,  8'hFF, 16'd7,  16'd6,   258, 16'd6,   1'b1, 1'b0, 16'd256, 0);
      run("err_s",    16'd143, 8'd7, 16'd143, 16'd0,  2,   16'd0,   1'b0, 1'b1, 16'd0,   0);
      run("err_n1",   16'd0,  8'd7, 16'd1,   16'd0,   2,   16'd0,   1'b0, 1'b1, 16'd0,   0);
      run("err_m",    16'd2,  8'd7, 16'd143, 16'd143, 2,   16'd0,   1'b0, 1'b1, 16'd0,   0);
      // err clears on the next accepted start
      run("after_err", 16'd2, 8'd7, 16'd143, 16'd128, 178, 16'd128, 1'b1, 1'b0, 16'd176, 0);
      // restart attempt and operand changes mid-operation are ignored
      run("ignore",   16'd2,  8'd7, 16'd143, 16'd128, 178, 16'd128, 1'b1, 1'b0, 16'd176, 50);

      // reset during an operation
      s = 16'd2; e = 8'd7; n = 16'd143; m = 16'd128;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_result", result, 16'd0);
      check("abort_busy", busy, 1'b0);
      check("abort_finish", finish, 1'b0);
      check("abort_valid", valid, 1'b0);
      check("abort_err", err, 1'b0);
      check("abort_cycles", cycles, 16'd0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("abort_no_finish", finish, 1'b0);
      end
      rst_n = 1'b1;
      run("post_rst", 16'd10, 8'd3, 16'd143, 16'd142, 162, 16'd142, 1'b1, 1'b0, 16'd160, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
